// File: rtl/bist_scan_sequencer.sv
// bist_scan_sequencer: sequences one scan-based BIST session.
// Flow is INIT, then N_PATTERNS x (CHAIN_LEN shift cycles + 1 capture cycle),
// then CHAIN_LEN flush cycles, then DONE. Every output is a flop whose next
// value is decoded from the next state, so START never reaches an output
// combinationally.
module bist_scan_sequencer #(
  parameter int CHAIN_LEN  = 8,
  parameter int N_PATTERNS = 16,
  parameter int PAT_W      = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  output logic             SCAN_EN,
  output logic             INIT,
  output logic             RUNNING,
  output logic             FINISH,
  output logic             BIST_END,
  output logic [PAT_W-1:0] PATTERN_CNT
);

  localparam int CNT_W = 8;

  localparam logic [CNT_W-1:0] CHAIN_LAST = CNT_W'(CHAIN_LEN - 1);
  localparam logic [PAT_W-1:0] PAT_LAST   = PAT_W'(N_PATTERNS);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_INIT    = 3'd1;
  localparam logic [2:0] ST_SHIFT   = 3'd2;
  localparam logic [2:0] ST_CAPTURE = 3'd3;
  localparam logic [2:0] ST_FLUSH   = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;

  // Reject parameter sets the counters cannot represent.
  if (CHAIN_LEN < 1 || CHAIN_LEN > 255) begin : g_bad_chain
    $fatal(1, "bist_scan_sequencer: CHAIN_LEN must be in 1..255");
  end
  if (N_PATTERNS < 1 || (N_PATTERNS >> PAT_W) != 0) begin : g_bad_pat
    $fatal(1, "bist_scan_sequencer: N_PATTERNS must be in 1..2^PAT_W-1");
  end

  logic [2:0]       state_q, state_d;
  logic             start_d_q;
  logic             armed_q;
  logic [CNT_W-1:0] shift_cnt_q, shift_cnt_d;
  logic [PAT_W-1:0] pattern_cnt_q, pattern_cnt_d;
  logic [PAT_W-1:0] pattern_inc;
  logic             scan_en_q, scan_en_d;
  logic             init_q, init_d;
  logic             running_q, running_d;
  logic             finish_q, finish_d;
  logic             bist_end_q, bist_end_d;
  logic             start_rise;

  // armed_q stays low for the first edge after reset. That way a START held
  // high through reset release is absorbed into start_d_q instead of being
  // taken as a fresh request; a new 0->1 edge is needed.
  assign start_rise  = START & ~start_d_q & armed_q;
  assign pattern_inc = pattern_cnt_q + 1'b1;

  // Next-state, shift counter and pattern counter.
  always_comb begin
    state_d       = state_q;
    shift_cnt_d   = shift_cnt_q;
    pattern_cnt_d = pattern_cnt_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_rise) begin
          state_d       = ST_INIT;
          pattern_cnt_d = '0;
        end
      end
      ST_INIT: begin
        state_d     = ST_SHIFT;
        shift_cnt_d = '0;
      end
      ST_SHIFT: begin
        if (shift_cnt_q == CHAIN_LAST) begin
          state_d     = ST_CAPTURE;
          shift_cnt_d = '0;
        end else begin
          shift_cnt_d = shift_cnt_q + 1'b1;
        end
      end
      ST_CAPTURE: begin
        pattern_cnt_d = pattern_inc;
        shift_cnt_d   = '0;
        if (pattern_inc == PAT_LAST) begin
          state_d = ST_FLUSH;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_FLUSH: begin
        if (shift_cnt_q == CHAIN_LAST) begin
          state_d     = ST_DONE;
          shift_cnt_d = '0;
        end else begin
          shift_cnt_d = shift_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d       = ST_IDLE;
        shift_cnt_d   = '0;
        pattern_cnt_d = '0;
      end
    endcase
  end

  // Output decode from the next state so the registered outputs line up
  // with the state register.
  always_comb begin
    scan_en_d  = (state_d == ST_SHIFT) || (state_d == ST_FLUSH);
    init_d     = (state_d == ST_INIT);
    running_d  = (state_d == ST_INIT) || (state_d == ST_SHIFT) ||
                 (state_d == ST_CAPTURE) || (state_d == ST_FLUSH);
    finish_d   = (state_d == ST_DONE) && (state_q != ST_DONE);
    bist_end_d = (state_d == ST_DONE);
  end

  // State, counters, START history and output registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q       <= ST_IDLE;
      start_d_q     <= 1'b0;
      armed_q       <= 1'b0;
      shift_cnt_q   <= '0;
      pattern_cnt_q <= '0;
      scan_en_q     <= 1'b0;
      init_q        <= 1'b0;
      running_q     <= 1'b0;
      finish_q      <= 1'b0;
      bist_end_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      start_d_q     <= START;
      armed_q       <= 1'b1;
      shift_cnt_q   <= shift_cnt_d;
      pattern_cnt_q <= pattern_cnt_d;
      scan_en_q     <= scan_en_d;
      init_q        <= init_d;
      running_q     <= running_d;
      finish_q      <= finish_d;
      bist_end_q    <= bist_end_d;
    end
  end

  assign SCAN_EN     = scan_en_q;
  assign INIT        = init_q;
  assign RUNNING     = running_q;
  assign FINISH      = finish_q;
  assign BIST_END    = bist_end_q;
  assign PATTERN_CNT = pattern_cnt_q;

endmodule

// File: tb/tb_bist_scan_sequencer.sv
// Testbench for bist_scan_sequencer: per-cycle vector tables for whole
// sessions on a CHAIN_LEN=8/N_PATTERNS=4 instance and a CHAIN_LEN=1/N_PATTERNS=1
// instance, plus hand-written reset sequences.
module tb_bist_scan_sequencer;

  typedef struct {
    logic       start;
    logic       scan_en;
    logic       init;
    logic       running;
    logic       finish;
    logic       bist_end;
    logic [7:0] pcnt;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic       start_a, start_b;
  logic       scan_a, init_a, run_a, fin_a, end_a;
  logic       scan_b, init_b, run_b, fin_b, end_b;
  logic [7:0] cnt_a, cnt_b;

  vec_t vecs[$];
  int   n_vec;
  int   n_miss;

  bist_scan_sequencer #(.CHAIN_LEN(8), .N_PATTERNS(4), .PAT_W(8)) dut (
    .CLK(clk), .RST(rst_n), .START(start_a),
    .SCAN_EN(scan_a), .INIT(init_a), .RUNNING(run_a), .FINISH(fin_a),
    .BIST_END(end_a), .PATTERN_CNT(cnt_a)
  );

  bist_scan_sequencer #(.CHAIN_LEN(1), .N_PATTERNS(1), .PAT_W(8)) dut_b (
    .CLK(clk), .RST(rst_n), .START(start_b),
    .SCAN_EN(scan_b), .INIT(init_b), .RUNNING(run_b), .FINISH(fin_b),
    .BIST_END(end_b), .PATTERN_CNT(cnt_b)
  );

  // 10 ns system clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one instance's outputs against an expected record.
  task automatic check_output(input string name, input int idx, input vec_t e, input bit sel);
    logic [12:0] act, exp;
    act = sel ? {scan_b, init_b, run_b, fin_b, end_b, cnt_b}
              : {scan_a, init_a, run_a, fin_a, end_a, cnt_a};
    exp = {e.scan_en, e.init, e.running, e.finish, e.bist_end, e.pcnt};
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s[%0d]: got scan_en=%b init=%b running=%b finish=%b bist_end=%b cnt=%0d, expected scan_en=%b init=%b running=%b finish=%b bist_end=%b cnt=%0d",
               name, idx, act[12], act[11], act[10], act[9], act[8], act[7:0],
               exp[12], exp[11], exp[10], exp[9], exp[8], exp[7:0]);
    end
  endtask

  task automatic push_vec(input int n, input logic st, input logic sc, input logic in,
                          input logic rn, input logic fn, input logic en, input logic [7:0] c);
    vec_t v;
    v.start = st; v.scan_en = sc; v.init = in; v.running = rn;
    v.finish = fn; v.bist_end = en; v.pcnt = c;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  // Hand timeline of one session: INIT, (shift x cl, capture) x np, flush x cl,
  // first DONE with FINISH, then hold cycles in DONE. START is held high.
  task automatic build_session(input int cl, input int np, input int hold);
    push_vec(1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    for (int p = 0; p < np; p++) begin
      push_vec(cl, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'(p));
      push_vec(1,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'(p));
    end
    push_vec(cl,   1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'(np));
    push_vec(1,    1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'(np));
    push_vec(hold, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'(np));
  endtask

  // Drive each record's START after an edge, then check after the next edge.
  task automatic apply_stimulus(input string name, input bit sel, input int limit);
    int n;
    n = (limit < 0) ? vecs.size() : limit;
    for (int i = 0; i < n; i++) begin
      if (sel) start_b = vecs[i].start;
      else     start_a = vecs[i].start;
      @(posedge clk);
      #1;
      check_output(name, i, vecs[i], sel);
    end
  endtask

  initial begin
    vec_t zero;
    n_vec = 0;
    n_miss = 0;
    zero = '{start: 1'b0, scan_en: 1'b0, init: 1'b0, running: 1'b0,
             finish: 1'b0, bist_end: 1'b0, pcnt: 8'd0};
    rst_n   = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;

    // Reset held for 3 cycles, then 20 idle cycles with START low.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_output("reset", i, zero, 1'b0);
      check_output("reset_b", i, zero, 1'b1);
    end
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check_output("idle", i, zero, 1'b0);
    end

    // Nominal session; START stays high across the end without retriggering.
    vecs.delete();
    build_session(8, 4, 3);
    apply_stimulus("session1", 1'b0, -1);

    // Restart from DONE: START low for 2 cycles, then a new rising edge.
    vecs.delete();
    push_vec(2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd4);
    build_session(8, 4, 3);
    apply_stimulus("restart", 1'b0, -1);

    // START toggling through shift and capture must not disturb the session.
    vecs.delete();
    push_vec(2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd4);
    build_session(8, 4, 3);
    for (int k = 1; k < vecs.size() - 2; k++) begin
      vecs[k + 2].start = (k <= 40) ? logic'(k[0]) : 1'b0;
    end
    apply_stimulus("toggle", 1'b0, -1);

    // Asynchronous reset in the middle of pattern 2's shift (cycle 23).
    vecs.delete();
    build_session(8, 4, 0);
    apply_stimulus("pre_abort", 1'b0, 24);
    #3 rst_n = 1'b0;
    #1 check_output("async_reset", 0, zero, 1'b0);
    for (int i = 1; i < 3; i++) begin
      @(posedge clk); #1;
      check_output("async_reset", i, zero, 1'b0);
    end
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check_output("held_start", i, zero, 1'b0);
    end
    start_a = 1'b0;
    @(posedge clk); #1;
    check_output("start_low", 0, zero, 1'b0);
    vecs.delete();
    build_session(8, 4, 2);
    apply_stimulus("post_reset", 1'b0, -1);

    // Smallest legal configuration.
    vecs.delete();
    build_session(1, 1, 3);
    apply_stimulus("min_cfg", 1'b1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
